// File: rtl/tp_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tp_ram
// Brief   : True dual-port synchronous RAM, registered read address, port A
//           wins same-address write collisions.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tp_ram #(
  parameter int aw = 5,
  parameter int dw = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce_a,
  input  logic          we_a,
  input  logic          oe_a,
  input  logic [aw-1:0] addr_a,
  input  logic [dw-1:0] di_a,
  output logic [dw-1:0] do_a,
  input  logic          ce_b,
  input  logic          we_b,
  input  logic          oe_b,
  input  logic [aw-1:0] addr_b,
  input  logic [dw-1:0] di_b,
  output logic [dw-1:0] do_b
);

  localparam int c_depth = 2 ** aw;

  logic [dw-1:0] mem [0:c_depth-1];
  logic [aw-1:0] r_ra_a;
  logic [aw-1:0] r_ra_b;
  logic          w_wr_a;
  logic          w_wr_b;

  assign w_wr_a = ce_a & we_a;
  assign w_wr_b = ce_b & we_b;

  // Port A is written last so it overrides port B on a same-address collision.
  always_ff @(posedge clk) begin
    if (w_wr_b) mem[addr_b] <= di_b;
    if (w_wr_a) mem[addr_a] <= di_a;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ra_a <= '0;
      r_ra_b <= '0;
    end else begin
      if (ce_a) r_ra_a <= addr_a;
      if (ce_b) r_ra_b <= addr_b;
    end
  end

  // Reading through the registered address gives write-first behaviour on both ports.
  assign do_a = oe_a ? mem[r_ra_a] : '0;
  assign do_b = oe_b ? mem[r_ra_b] : '0;

endmodule
`default_nettype wire

// File: tb/tb_tp_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_tp_ram
// Brief   : Directed self-checking bench for tp_ram (aw=11, dw=8).
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_tp_ram;

  localparam int c_aw = 11;
  localparam int c_dw = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            ce_a = 1'b0, we_a = 1'b0, oe_a = 1'b0;
  logic            ce_b = 1'b0, we_b = 1'b0, oe_b = 1'b0;
  logic [c_aw-1:0] addr_a = '0, addr_b = '0;
  logic [c_dw-1:0] di_a = '0, di_b = '0;
  logic [c_dw-1:0] do_a, do_b;

  int tests  = 0;
  int errors = 0;

  tp_ram #(.aw(c_aw), .dw(c_dw)) dut (
    .clk(clk), .rst(rst),
    .ce_a(ce_a), .we_a(we_a), .oe_a(oe_a), .addr_a(addr_a), .di_a(di_a), .do_a(do_a),
    .ce_b(ce_b), .we_b(we_b), .oe_b(oe_b), .addr_b(addr_b), .di_b(di_b), .do_b(do_b)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce_a = 1'b0; we_a = 1'b0;
    ce_b = 1'b0; we_b = 1'b0;
  endtask

  task automatic check(input string name, input logic [c_dw-1:0] act, input logic [c_dw-1:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    ce_a = 1'b1; we_a = 1'b1; addr_a = 0; di_a = 8'hA5;
    tick();
    idle();
    oe_a = 1'b1;
    #1;
    check("reset_ra_a_zero", do_a, 8'hA5);
    rst = 1'b0;
    ce_b = 1'b1; oe_b = 1'b1; addr_b = 0;
    tick();
    check("reset_read_b", do_b, 8'hA5);
    oe_b = 1'b0;
    #1;
    check("oe_b_low_zero", do_b, 8'h00);
    oe_a = 1'b0;
    #1;
    check("oe_a_low_zero", do_a, 8'h00);
    idle();
  endtask

  task automatic test_sweep();
    logic [c_aw-1:0] a;
    int bad = 0;
    ce_a = 1'b1; we_a = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      a = c_aw'(i);
      addr_a = a; di_a = a[7:0];
      tick();
    end
    idle();
    ce_b = 1'b1; oe_b = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      a = c_aw'(i);
      addr_b = a;
      tick();
      tests++;
      if (do_b !== a[7:0]) begin
        errors++;
        bad++;
        if (bad <= 5) $display("FAIL sweep_addr_%0d: got 0x%02h expected 0x%02h", i, do_b, a[7:0]);
      end
    end
    idle();
  endtask

  task automatic test_ce_gating();
    ce_a = 1'b0; we_a = 1'b1; addr_a = 5; di_a = 8'hFF;
    tick();
    idle();
    ce_b = 1'b1; oe_b = 1'b1; addr_b = 5;
    tick();
    check("ce_a_blocks_write", do_b, 8'h05);
    ce_b = 1'b0; addr_b = 6;
    tick();
    check("ce_b_holds_addr", do_b, 8'h05);
    ce_b = 1'b1;
    tick();
    check("ce_b_captures_addr", do_b, 8'h06);
    idle();
  endtask

  task automatic test_collisions();
    ce_a = 1'b1; we_a = 1'b1; addr_a = 100; di_a = 8'h3C;
    ce_b = 1'b1; we_b = 1'b0; oe_b = 1'b1; addr_b = 100;
    tick();
    check("cross_port_write_read", do_b, 8'h3C);
    ce_a = 1'b1; we_a = 1'b1; addr_a = 7; di_a = 8'h11;
    ce_b = 1'b1; we_b = 1'b1; addr_b = 7; di_b = 8'h22;
    oe_a = 1'b1;
    tick();
    check("dual_write_a_wins_a", do_a, 8'h11);
    check("dual_write_a_wins_b", do_b, 8'h11);
    idle();
    oe_a = 1'b0;
  endtask

  task automatic test_write_first();
    ce_a = 1'b1; we_a = 1'b1; oe_a = 1'b1; addr_a = 9; di_a = 8'h77;
    tick();
    check("write_first_a", do_a, 8'h77);
    ce_b = 1'b1; we_b = 1'b1; oe_b = 1'b1; addr_b = 9; di_b = 8'h99;
    ce_a = 1'b0; we_a = 1'b0;
    tick();
    check("write_first_b", do_b, 8'h99);
    idle();
    oe_a = 1'b0;
  endtask

  task automatic test_async_reset();
    ce_a = 1'b1; we_a = 1'b1; addr_a = 0; di_a = 8'h5A;
    ce_b = 1'b1; oe_b = 1'b1; addr_b = 200;
    tick();
    idle();
    check("read_200_before_rst", do_b, 8'hC8);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_do_b_mem0", do_b, 8'h5A);
    #1;
    rst = 1'b0;
    ce_b = 1'b1; addr_b = 200;
    tick();
    check("read_200_after_rst", do_b, 8'hC8);
    idle();
  endtask

  initial begin
    #1;
    test_reset();
    test_sweep();
    test_ce_gating();
    test_collisions();
    test_write_first();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tp_ram.md
Name: tp_ram

Overview:
- Generic true dual-port synchronous RAM of 2**aw words, each dw bits wide.
- Both ports (A and B) can independently read or write.
- Used as the 2 KB history buffer in the LZS decoder:
  - port A writes decoded bytes;
  - port B reads back-referenced bytes at a computed offset.
- Infers to block RAM; no initialisation.

Parameters:
- aw, 5, address width; depth = 2**aw words (decoder instance uses 11).
- dw, 16, data width in bits (decoder instance uses 8).

Ports:
- clk  in  1  Clock for both ports; all sampling on the rising edge.
- rst  in  1  Reset, asynchronous, active-high; clears the address registers only.
- ce_a  in  1  Port A chip enable; gates write and address capture.
- we_a  in  1  Port A write enable, qualified by ce_a.
- oe_a  in  1  Port A output enable; do_a forced to 0 when low.
- addr_a  in  aw  Port A address.
- di_a  in  dw  Port A write data.
- do_a  out  dw  Port A read data.
- ce_b  in  1  Port B chip enable.
- we_b  in  1  Port B write enable, qualified by ce_b.
- oe_b  in  1  Port B output enable; do_b forced to 0 when low.
- addr_b  in  aw  Port B address.
- di_b  in  dw  Port B write data.
- do_b  out  dw  Port B read data.

Behaviour:
- Reset rst, asynchronous, active-high; clock clk.
- Storage: array mem[0 .. 2**aw-1] of dw bits. Contents are not reset; value before the first write is undefined (X in simulation).
- Write, per port p: on posedge clk, if ce_p & we_p, then mem[addr_p] <= di_p.
- Read address register, per port p:
  - on posedge clk, if ce_p, ra_p <= addr_p;
  - if ce_p is low, ra_p holds;
  - rst asynchronously forces ra_a = ra_b = 0.
- Read data: do_p = oe_p ? mem[ra_p] : 0, combinational from the registered address.
  - Read latency is one clock: the address presented in cycle N gives data valid after the edge ending cycle N.
  - A low oe_p drives zeros, not high-Z, so outputs can be OR-combined downstream.
- Read-during-write, same port and same address: write-first. After the edge, do_p shows the newly written data.
- Cross-port collision, one port writes address X while the other registers address X: after the edge the reader sees the new data.
- Both ports write the same address in the same cycle: port A's data wins; port B's write is discarded.
- Address arithmetic: addresses are plain aw-bit binary. The caller handles wrap (the decoder relies on natural mod 2**aw overflow).
- rst mid-operation:
  - ra registers clear immediately, so do_p shows mem[0] while oe_p is high;
  - any write in progress on that edge is still performed if ce & we are sampled high and rst is low at the edge;
  - while rst is high, writes are still permitted, since memory contents are not reset.
- No handshake, no busy/ready. Every cycle is accepted.

Decomposition:
- No shared package needed; aw and dw are module parameters only.
- Single flat module with no sub-modules.
- Optional thin per-port helper is not warranted; keep the array and both port processes in one file so synthesis infers a dual-port block RAM.

Test Plan:
- Reset and output enable: assert rst, write 0xA5 to addr 0 via A, release rst, oe_b=1, addr_b=0, ce_b=1 -> do_b=0xA5 one cycle later; set oe_b=0 -> do_b=0 combinationally.
- A-write / B-read sweep (aw=11, dw=8): write data = addr[7:0] to addresses 0..2047 on A, then read all on B -> each do_b equals addr[7:0] with 1-cycle latency.
- ce gating:
  - ce_a=0 with we_a=1 writing 0xFF to addr 5 leaves the prior value 0x05;
  - ce_b=0 while addr_b changes from 5 to 6 -> do_b stays 0x05.
- Collisions:
  - A writes 0x3C to addr 100 while B registers addr 100 -> next cycle do_b=0x3C;
  - A writes 0x11 and B writes 0x22 to addr 7 in the same cycle -> read gives 0x11.
- Same-port write-first: A writes 0x77 to addr 9 with oe_a=1 -> do_a=0x77 after the edge.
- Async reset mid-stream: B reading addr 200, assert rst between edges -> do_b switches to mem[0] immediately without waiting for a clock edge.
